// File: rtl/video_out_stage.sv
// Final video output stage: re-times sync strobes to the late colour pipeline, composites
// sprite over background, drives the registered PMOD word and a vblank frame tick / irq.
module video_out_stage #(
   parameter int unsigned SYNC_DELAY   = 2,
   parameter bit          VSYNC_ACTIVE = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic        visible_in,
   input  logic        sprite_on_in,
   input  logic [1:0]  bg_r,
   input  logic [1:0]  bg_g,
   input  logic [1:0]  bg_b,
   input  logic        cfg_wr,
   input  logic [1:0]  cfg_addr,
   input  logic [15:0] cfg_wdata,
   output logic [15:0] cfg_rdata,
   output logic [7:0]  uo_out,
   output logic        irq
);

   localparam int unsigned COL_W   = 6;
   localparam int unsigned TAG_W   = 4;
   localparam int unsigned CTRL_W  = 4;
   localparam int unsigned FRAME_W = 16;

   localparam logic [1:0] ADDR_CTRL   = 2'd0;
   localparam logic [1:0] ADDR_SPR    = 2'd1;
   localparam logic [1:0] ADDR_FRAME  = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   // Tag carried down the delay line: {valid, visible, vsync, hsync}.
   // The valid bit marks stages still holding reset fill rather than real strobes.
   logic [TAG_W-1:0] tag_in;
   logic [TAG_W-1:0] tag_d;
   logic             tag_valid;
   logic             vis_d;
   logic             vs_d;
   logic             hs_d;

   assign tag_in = {1'b1, visible_in, vsync_in, hsync_in};
   assign {tag_valid, vis_d, vs_d, hs_d} = tag_d;

   if (SYNC_DELAY == 0) begin : g_wire
      assign tag_d = tag_in;
   end else begin : g_dly
      logic [TAG_W-1:0] dly_q [SYNC_DELAY];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int unsigned i = 0; i < SYNC_DELAY; i++) dly_q[i] <= '0;
         end else begin
            dly_q[0] <= tag_in;
            for (int unsigned i = 1; i < SYNC_DELAY; i++) dly_q[i] <= dly_q[i-1];
         end
      end

      assign tag_d = dly_q[SYNC_DELAY-1];
   end

   logic [CTRL_W-1:0]  ctrl_q,    ctrl_d;
   logic [COL_W-1:0]   spr_q,     spr_d;
   logic [FRAME_W-1:0] frame_q,   frame_d;
   logic               pend_q,    pend_d;
   logic               vs_prev_q, vs_prev_d;
   logic [7:0]         uo_q,      uo_d;

   logic [COL_W-1:0] colour;
   logic             vs_eff;
   logic             frame_evt;
   logic             wr_ctrl, wr_spr, wr_frame, wr_status;
   logic             wdata_unused;

   assign wr_ctrl      = cfg_wr && (cfg_addr == ADDR_CTRL);
   assign wr_spr       = cfg_wr && (cfg_addr == ADDR_SPR);
   assign wr_frame     = cfg_wr && (cfg_addr == ADDR_FRAME);
   assign wr_status    = cfg_wr && (cfg_addr == ADDR_STATUS);
   assign wdata_unused = ^cfg_wdata[15:COL_W];

   // Reset fill counts as the active level so a held vsync never looks like a fresh edge.
   assign vs_eff    = tag_valid ? vs_d : VSYNC_ACTIVE;
   assign frame_evt = (vs_eff == VSYNC_ACTIVE) && (vs_prev_q != VSYNC_ACTIVE);

   always_comb begin
      colour = '0;
      if (vis_d) begin
         if (sprite_on_in && ctrl_q[0]) colour = spr_q;
         else if (ctrl_q[1])            colour = {bg_b, bg_g, bg_r} ^ {COL_W{ctrl_q[2]}};
      end
   end

   // Frame event outranks same-cycle FRAME clear (giving 1) and PENDING clear.
   always_comb begin
      ctrl_d    = ctrl_q;
      spr_d     = spr_q;
      frame_d   = frame_q;
      pend_d    = pend_q;
      vs_prev_d = vs_eff;
      uo_d      = {vs_d, hs_d, colour};
      if (wr_ctrl) ctrl_d = cfg_wdata[CTRL_W-1:0];
      if (wr_spr)  spr_d  = cfg_wdata[COL_W-1:0];
      if (wr_frame) frame_d = '0;
      if (frame_evt) frame_d = frame_d + FRAME_W'(1);
      if (frame_evt)                     pend_d = 1'b1;
      else if (wr_status && cfg_wdata[0]) pend_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctrl_q    <= CTRL_W'(4'h3);
         spr_q     <= COL_W'(6'h3F);
         frame_q   <= '0;
         pend_q    <= 1'b0;
         vs_prev_q <= VSYNC_ACTIVE;
         uo_q      <= '0;
      end else begin
         ctrl_q    <= ctrl_d;
         spr_q     <= spr_d;
         frame_q   <= frame_d;
         pend_q    <= pend_d;
         vs_prev_q <= vs_prev_d;
         uo_q      <= uo_d;
      end
   end

   always_comb begin
      cfg_rdata = '0;
      case (cfg_addr)
         ADDR_CTRL:  cfg_rdata = {12'h000, ctrl_q};
         ADDR_SPR:   cfg_rdata = {10'h000, spr_q};
         ADDR_FRAME: cfg_rdata = frame_q;
         default:    cfg_rdata = {15'h0000, pend_q};
      endcase
   end

   assign uo_out = uo_q;
   assign irq    = pend_q & ctrl_q[3];

endmodule
